// File: rtl/spike_count_classifier.sv
// spike_count_classifier: counts per-neuron spikes over a fixed window, then scans for the winning class.
module spike_count_classifier #(
  parameter int NUM_NEURONS = 4,
  parameter int COUNT_WIDTH = 8,
  parameter int WINDOW_CYCLES = 100,
  localparam int IW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [NUM_NEURONS-1:0] spike_in,
  output logic                   busy,
  output logic                   result_valid,
  input  logic                   result_ready,
  output logic [IW-1:0]          class_out,
  output logic [COUNT_WIDTH-1:0] max_count,
  output logic                   no_spike
);
  localparam int TW = $clog2(WINDOW_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, COUNT, SCAN, DONE} state_t;
  state_t state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [IW-1:0] idx_q, idx_d, run_cls_q, run_cls_d, cls_q, cls_d, new_cls;
  logic [COUNT_WIDTH-1:0] cnt_q [NUM_NEURONS];
  logic [COUNT_WIDTH-1:0] cnt_d [NUM_NEURONS];
  logic [COUNT_WIDTH-1:0] run_max_q, run_max_d, max_q, max_d, new_max;
  logic no_spike_q, no_spike_d, last_idx, last_sample;
  assign last_idx    = idx_q == IW'(NUM_NEURONS - 1);
  assign last_sample = timer_q == TW'(1);
  // strict compare keeps the lowest index on ties
  assign new_max = (cnt_q[idx_q] > run_max_q) ? cnt_q[idx_q] : run_max_q;
  assign new_cls = (cnt_q[idx_q] > run_max_q) ? idx_q : run_cls_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      idx_q      <= '0;
      run_cls_q  <= '0;
      run_max_q  <= '0;
      cls_q      <= '0;
      max_q      <= '0;
      no_spike_q <= 1'b0;
      cnt_q      <= '{default: '0};
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      idx_q      <= idx_d;
      run_cls_q  <= run_cls_d;
      run_max_q  <= run_max_d;
      cls_q      <= cls_d;
      max_q      <= max_d;
      no_spike_q <= no_spike_d;
      cnt_q      <= cnt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? COUNT : IDLE;
      COUNT:   state_d = last_sample ? SCAN : COUNT;
      SCAN:    state_d = last_idx ? DONE : SCAN;
      DONE:    state_d = result_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    timer_d    = timer_q;
    idx_d      = idx_q;
    run_cls_d  = run_cls_q;
    run_max_d  = run_max_q;
    cls_d      = cls_q;
    max_d      = max_q;
    no_spike_d = no_spike_q;
    cnt_d      = cnt_q;
    if (state_q == IDLE && start) begin
      timer_d = TW'(WINDOW_CYCLES);
      for (int i = 0; i < NUM_NEURONS; i++) cnt_d[i] = '0;
    end
    if (state_q == COUNT) begin
      timer_d = timer_q - TW'(1);
      for (int i = 0; i < NUM_NEURONS; i++)
        cnt_d[i] = cnt_q[i] + COUNT_WIDTH'(spike_in[i] && !(&cnt_q[i]));
      idx_d     = last_sample ? '0 : idx_q;
      run_max_d = last_sample ? '0 : run_max_q;
      run_cls_d = last_sample ? '0 : run_cls_q;
    end
    if (state_q == SCAN) begin
      idx_d      = idx_q + IW'(1);
      run_max_d  = new_max;
      run_cls_d  = new_cls;
      cls_d      = last_idx ? new_cls : cls_q;
      max_d      = last_idx ? new_max : max_q;
      no_spike_d = last_idx ? (new_max == '0) : no_spike_q;
    end
  end
  always_comb begin
    busy         = state_q != IDLE;
    result_valid = state_q == DONE;
    class_out    = cls_q;
    max_count    = max_q;
    no_spike     = no_spike_q;
  end
endmodule

// File: tb/tb_spike_count_classifier.sv
// tb_spike_count_classifier: random and directed windows on two instances (window 10 and 20) checked against a timeline model.
module tb_spike_count_classifier;
  logic clk = 1'b0, rst = 1'b0;
  logic [1:0] start_s = '0, ready_s = '0;
  logic [3:0] spk_s [2];
  logic [1:0] busy_o, valid_o, ns_o;
  logic [1:0] cls_o [2];
  logic [3:0] max_o [2];
  int checks = 0, errors = 0, lat;
  bit cmp_en = 1'b0;
  int m_t [2], m_cls [2], m_max [2];
  int m_cnt [2][4];
  bit [1:0] m_busy, m_valid, m_ns;

  always #5 clk = ~clk;

  spike_count_classifier #(.NUM_NEURONS(4), .COUNT_WIDTH(4), .WINDOW_CYCLES(10)) dut_a (
    .clk(clk), .rst(rst), .start(start_s[0]), .spike_in(spk_s[0]), .busy(busy_o[0]),
    .result_valid(valid_o[0]), .result_ready(ready_s[0]), .class_out(cls_o[0]),
    .max_count(max_o[0]), .no_spike(ns_o[0]));
  spike_count_classifier #(.NUM_NEURONS(4), .COUNT_WIDTH(4), .WINDOW_CYCLES(20)) dut_b (
    .clk(clk), .rst(rst), .start(start_s[1]), .spike_in(spk_s[1]), .busy(busy_o[1]),
    .result_valid(valid_o[1]), .result_ready(ready_s[1]), .class_out(cls_o[1]),
    .max_count(max_o[1]), .no_spike(ns_o[1]));

  function automatic int wof(input int k);
    return (k != 0) ? 20 : 10;
  endfunction

  function automatic int amax(input int k);
    int b = 0;
    for (int i = 1; i < 4; i++) if (m_cnt[k][i] > m_cnt[k][b]) b = i;
    return b;
  endfunction

  // m_t counts edges since the accepting edge; samples land on 1..W, result on W+4
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        m_busy[k] <= 1'b0; m_valid[k] <= 1'b0; m_ns[k] <= 1'b0;
        m_t[k] <= 0; m_cls[k] <= 0; m_max[k] <= 0;
        for (int i = 0; i < 4; i++) m_cnt[k][i] <= 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (!m_busy[k]) begin
          if (start_s[k]) begin
            m_busy[k] <= 1'b1;
            m_t[k] <= 0;
            for (int i = 0; i < 4; i++) m_cnt[k][i] <= 0;
          end
        end else if (m_valid[k]) begin
          if (ready_s[k]) begin
            m_valid[k] <= 1'b0;
            m_busy[k] <= 1'b0;
          end
        end else begin
          m_t[k] <= m_t[k] + 1;
          if (m_t[k] + 1 <= wof(k))
            for (int i = 0; i < 4; i++)
              m_cnt[k][i] <= (m_cnt[k][i] + int'(spk_s[k][i]) > 15) ? 15 : m_cnt[k][i] + int'(spk_s[k][i]);
          if (m_t[k] + 1 == wof(k) + 4) begin
            m_valid[k] <= 1'b1;
            m_cls[k] <= amax(k);
            m_max[k] <= m_cnt[k][amax(k)];
            m_ns[k] <= (m_cnt[k][amax(k)] == 0);
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("busy%0d", k), int'(busy_o[k]), int'(m_busy[k]));
        chk($sformatf("valid%0d", k), int'(valid_o[k]), int'(m_valid[k]));
        chk($sformatf("class%0d", k), int'(cls_o[k]), m_cls[k]);
        chk($sformatf("max%0d", k), int'(max_o[k]), m_max[k]);
        chk($sformatf("no_spike%0d", k), int'(ns_o[k]), int'(m_ns[k]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic run(input int k, input int mode, input int hold, output int l);
    int w = wof(k);
    logic [3:0] s;
    start_s[k] = 1'b1;
    step();
    start_s[k] = 1'b0;
    for (int j = 0; j < w; j++) begin
      case (mode)
        0: s = 4'b0100;
        1: s = 4'b0000;
        2: s = (j < 2) ? 4'b1011 : (j < 6) ? 4'b1010 : 4'b0000;
        3: s = 4'b0001;
        5: s = (j < 3) ? 4'b1000 : 4'b0000;
        6: s = 4'($urandom) | 4'($urandom);
        default: s = 4'($urandom);
      endcase
      spk_s[k] = s;
      if (mode >= 4) begin
        ready_s[k] = 1'($urandom);
        start_s[k] = 1'($urandom);
      end
      step();
    end
    spk_s[k] = '0; ready_s[k] = 1'b0; start_s[k] = 1'b0;
    l = w;
    while (!valid_o[k] && l < w + 40) begin
      step();
      l++;
    end
    chk("valid_seen", int'(valid_o[k]), 1);
    for (int h = 0; h < hold; h++) begin
      spk_s[k] = 4'($urandom);
      start_s[k] = 1'(h % 2 == 0);
      step();
      chk("held_valid", int'(valid_o[k]), 1);
    end
    start_s[k] = 1'b0; spk_s[k] = '0;
    ready_s[k] = 1'b1;
    step();
    ready_s[k] = 1'b0;
    chk("valid_dropped", int'(valid_o[k]), 0);
  endtask

  initial begin
    spk_s[0] = '0;
    spk_s[1] = '0;
    step();
    cmp_en = 1'b1;
    step();
    chk("rst_busy", int'(busy_o[0]), 0);
    chk("rst_valid", int'(valid_o[0]), 0);
    chk("rst_class", int'(cls_o[0]), 0);
    chk("rst_max", int'(max_o[0]), 0);
    chk("rst_nospike", int'(ns_o[0]), 0);
    rst = 1'b1;
    step();
    run(0, 0, 0, lat);
    chk("s1_latency", lat, 14);
    chk("s1_class", m_cls[0], 2);
    chk("s1_max", m_max[0], 10);
    chk("s1_nospike", int'(m_ns[0]), 0);
    run(0, 1, 0, lat);
    chk("s2_class", m_cls[0], 0);
    chk("s2_max", m_max[0], 0);
    chk("s2_nospike", int'(m_ns[0]), 1);
    run(0, 2, 0, lat);
    chk("s3_class", m_cls[0], 1);
    chk("s3_max", m_max[0], 6);
    run(1, 3, 0, lat);
    chk("s4_latency", lat, 24);
    chk("s4_class", m_cls[1], 0);
    chk("s4_max", m_max[1], 15);
    run(0, 4, 5, lat);
    run(0, 0, 0, lat);
    chk("s5_class", m_cls[0], 2);
    chk("s5_max", m_max[0], 10);
    start_s[0] = 1'b1;
    step();
    start_s[0] = 1'b0;
    for (int j = 0; j < 5; j++) begin
      spk_s[0] = 4'($urandom);
      step();
    end
    rst = 1'b0;
    step();
    chk("s6_rst_busy", int'(busy_o[0]), 0);
    rst = 1'b1;
    spk_s[0] = '0;
    for (int j = 0; j < 20; j++) begin
      step();
      chk("s6_no_valid", int'(valid_o[0]), 0);
    end
    run(0, 5, 0, lat);
    chk("s6_class", m_cls[0], 3);
    chk("s6_max", m_max[0], 3);
    for (int r = 0; r < 10; r++) run(0, 4, $urandom_range(0, 3), lat);
    for (int r = 0; r < 4; r++) run(1, 6, $urandom_range(0, 3), lat);
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
